// File: rtl/cache_fill_pkg.sv
// Shared types and helpers for the cache block fill controller.
// The width localparams describe the default geometry; instances derive their own from parameters.
package cache_fill_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam int unsigned DEF_WORD_BYTES  = 2;
  localparam int unsigned DEF_BLOCK_WORDS = 8;
  localparam int unsigned OFF_W = $clog2(DEF_WORD_BYTES);
  localparam int unsigned IDX_W = $clog2(DEF_BLOCK_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;

  // Byte address of word n of a block; the index wraps inside the block and never carries into base.
  function automatic logic [31:0] blk_word_addr(input logic [31:0] base,
                                                input logic [31:0] start,
                                                input logic [31:0] n,
                                                input int unsigned off_w,
                                                input int unsigned idx_w);
    logic [31:0] idx;
    idx = (start + n) & ((32'd1 << idx_w) - 32'd1);
    return base | (idx << off_w);
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Clear/enable word counter with a terminal-count flag, used for request issue and response tracking.
module fill_word_counter #(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned BLOCK_WORDS = 8,
  parameter bit          TC_LAST     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  // TC_LAST flags the final word slot; otherwise the flag marks a full block.
  localparam logic [CNT_W-1:0] TC_VAL = TC_LAST ? CNT_W'(BLOCK_WORDS - 1) : CNT_W'(BLOCK_WORDS);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache block fill controller: issues one block of word requests with ready handshake and
// writes returning words into the data array, in linear or critical-word-first order.
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WORD_BYTES  = DEF_WORD_BYTES,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter bit          CWF_EN      = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  input  logic                           cwf_mode,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic [ADDR_W-1:0]              mem_req_addr,
  input  logic                           memory_data_valid,
  output logic                           fsm_busy,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] write_word_idx,
  output logic                           write_tag_array,
  output logic                           fill_done
);

  localparam int unsigned BLK_OFF_W = $clog2(WORD_BYTES);
  localparam int unsigned BLK_IDX_W = $clog2(BLOCK_WORDS);
  localparam int unsigned BLK_CNT_W = BLK_IDX_W + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK =
    ADDR_W'((64'd1 << (BLK_OFF_W + BLK_IDX_W)) - 64'd1);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [BLK_IDX_W-1:0]   word_q, word_d;
  logic                   mode_q, mode_d;
  logic [BLK_IDX_W-1:0]   start;
  logic [BLK_CNT_W-1:0]   req_cnt, rsp_cnt;
  logic                   req_full, rsp_last;
  logic                   accept, req_fire, rsp_ok;

  fill_word_counter #(
    .CNT_W      (BLK_CNT_W),
    .BLOCK_WORDS(BLOCK_WORDS),
    .TC_LAST    (1'b0)
  ) u_req_cnt (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(accept),
    .en_i (req_fire),
    .cnt_o(req_cnt),
    .tc_o (req_full)
  );

  fill_word_counter #(
    .CNT_W      (BLK_CNT_W),
    .BLOCK_WORDS(BLOCK_WORDS),
    .TC_LAST    (1'b1)
  ) u_rsp_cnt (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(accept),
    .en_i (rsp_ok),
    .cnt_o(rsp_cnt),
    .tc_o (rsp_last)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    word_d  = word_q;
    mode_d  = mode_q;

    start    = mode_q ? word_q : '0;
    accept   = (state_q == IDLE) && miss_detected;
    fsm_busy = (state_q == FILL);

    mem_req_valid = (state_q == FILL) && !req_full;
    req_fire      = mem_req_valid && mem_req_ready;
    // Address is forced to zero when idle so every output reads 0 out of reset.
    mem_req_addr  = mem_req_valid ?
      ADDR_W'(blk_word_addr(32'(base_q), 32'(start), 32'(req_cnt), BLK_OFF_W, BLK_IDX_W)) : '0;

    // A response beyond the issued requests is a protocol error and is dropped.
    rsp_ok           = (state_q == FILL) && memory_data_valid && (rsp_cnt < req_cnt);
    write_data_array = rsp_ok;
    write_word_idx   = rsp_ok ?
      BLK_IDX_W'(blk_word_addr(32'd0, 32'(start), 32'(rsp_cnt), 0, BLK_IDX_W)) : '0;
    write_tag_array  = rsp_ok && rsp_last;
    fill_done        = rsp_ok && rsp_last;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d = FILL;
          base_d  = miss_address & ~BLK_MASK;
          word_d  = miss_address[BLK_OFF_W +: BLK_IDX_W];
          mode_d  = cwf_mode;
        end
      end
      FILL: begin
        if (rsp_ok && rsp_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      word_q  <= '0;
      mode_q  <= CWF_EN;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: a block-arithmetic model queues expected requests and
// writes; negedge monitors pop and compare whenever the DUT issues a request or a write.
module tb_cache_fill_ctrl;

  typedef struct {
    int unsigned idx;
    bit          last;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, miss_detected, cwf_mode, mem_req_ready, memory_data_valid;
  logic [15:0] miss_address;
  logic        mem_req_valid, fsm_busy, write_data_array, write_tag_array, fill_done;
  logic [15:0] mem_req_addr;
  logic [2:0]  write_word_idx;

  logic        b_miss, b_cwf, b_ready, b_mdv;
  logic [15:0] b_addr;
  logic        b_req_valid, b_busy, b_wr, b_tag, b_done;
  logic [15:0] b_req_addr;
  logic [1:0]  b_idx;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int unsigned lat = 4;
  int unsigned ready_mode = 0;
  bit          bogus = 1'b0;
  int          acc_cnt = 0;
  int          done_seen = 0;
  int          b_done_seen = 0;
  int          wr_total = 0;
  int          pend[$];
  int          pend_b[$];
  logic [15:0] exp_req[$];
  logic [15:0] exp_req_b[$];
  wr_t         exp_wr[$];
  wr_t         exp_wr_b[$];

  cache_fill_ctrl #(
    .ADDR_W(16), .WORD_BYTES(2), .BLOCK_WORDS(8), .CWF_EN(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .cwf_mode(cwf_mode), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy),
    .write_data_array(write_data_array), .write_word_idx(write_word_idx),
    .write_tag_array(write_tag_array), .fill_done(fill_done)
  );

  cache_fill_ctrl #(
    .ADDR_W(16), .WORD_BYTES(4), .BLOCK_WORDS(4), .CWF_EN(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .miss_detected(b_miss), .miss_address(b_addr),
    .cwf_mode(b_cwf), .mem_req_valid(b_req_valid), .mem_req_ready(b_ready),
    .mem_req_addr(b_req_addr), .memory_data_valid(b_mdv), .fsm_busy(b_busy),
    .write_data_array(b_wr), .write_word_idx(b_idx),
    .write_tag_array(b_tag), .fill_done(b_done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: block base by integer division, word k of the miss, slot (k+n) mod words.
  task automatic push_fill(input int unsigned addr, input bit cwf, input int unsigned wb,
                           input int unsigned bw, input bit to_b);
    int unsigned blk, base, k, idx;
    wr_t w;
    blk  = wb * bw;
    base = (addr / blk) * blk;
    k    = cwf ? (addr / wb) % bw : 0;
    for (int unsigned n = 0; n < bw; n++) begin
      idx    = (k + n) % bw;
      w.idx  = idx;
      w.last = (n == bw - 1);
      if (to_b) begin
        exp_req_b.push_back(16'(base + idx * wb));
        exp_wr_b.push_back(w);
      end else begin
        exp_req.push_back(16'(base + idx * wb));
        exp_wr.push_back(w);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       mem_req_ready = 1'b1;
      1:       mem_req_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       mem_req_ready = 1'($urandom_range(0, 1));
      default: mem_req_ready = 1'b0;
    endcase
    memory_data_valid = 1'b0;
    if (bogus) begin
      memory_data_valid = 1'b1;
    end else if (pend.size() > 0 && pend[0] <= cyc) begin
      void'(pend.pop_front());
      memory_data_valid = 1'b1;
    end
    b_ready = 1'b1;
    b_mdv   = 1'b0;
    if (pend_b.size() > 0 && pend_b[0] <= cyc) begin
      void'(pend_b.pop_front());
      b_mdv = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget);
    int target, k;
    target = done_seen + 1;
    k = 0;
    while (done_seen < target && k < budget) begin
      tick();
      k++;
    end
    check("fill_timeout", done_seen >= target, 1);
  endtask

  task automatic start_fill(input logic [15:0] addr, input bit cwf);
    push_fill(addr, cwf, 2, 8, 1'b0);
    tick();
    miss_detected = 1'b1;
    miss_address  = addr;
    cwf_mode      = cwf;
    @(negedge clk);
    check("busy_before_accept", fsm_busy, 0);
    tick();
    miss_detected = 1'b0;
    miss_address  = 16'($urandom);
    cwf_mode      = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("busy_after_accept", fsm_busy, 1);
  endtask

  task automatic run_fill(input logic [15:0] addr, input bit cwf, input int unsigned rmode,
                          input int unsigned l);
    lat = l;
    ready_mode = rmode;
    start_fill(addr, cwf);
    wait_done(600);
  endtask

  initial begin : mon_a
    wr_t         e;
    bit          hold_v, was_done;
    logic [15:0] hold_a;
    hold_v = 1'b0;
    was_done = 1'b0;
    hold_a = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
        was_done = 1'b0;
        acc_cnt = 0;
      end else begin
        if (was_done) check("busy_after_done", fsm_busy, 0);
        was_done = fill_done;
        if (hold_v) begin
          check("req_hold_valid", mem_req_valid, 1);
          check("req_hold_addr", mem_req_addr, hold_a);
        end
        hold_v = mem_req_valid && !mem_req_ready;
        hold_a = mem_req_addr;
        if (mem_req_valid && mem_req_ready) begin
          pend.push_back(cyc + int'(lat));
          acc_cnt++;
          check("req_expected", exp_req.size() > 0, 1);
          if (exp_req.size() > 0) check("req_addr", mem_req_addr, exp_req.pop_front());
        end
        if (write_data_array) begin
          wr_total++;
          check("wr_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            check("wr_idx", write_word_idx, e.idx);
            check("wr_tag", write_tag_array, e.last);
            check("fill_done", fill_done, e.last);
          end
        end else if (fill_done || write_tag_array) begin
          check("done_without_write", {fill_done, write_tag_array}, 0);
        end
        if (fill_done) begin
          check("busy_at_done", fsm_busy, 1);
          check("req_count", acc_cnt, 8);
          acc_cnt = 0;
          done_seen++;
        end
      end
    end
  end

  initial begin : mon_b
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (b_req_valid && b_ready) begin
          pend_b.push_back(cyc + 1);
          check("b_req_expected", exp_req_b.size() > 0, 1);
          if (exp_req_b.size() > 0) check("b_req_addr", b_req_addr, exp_req_b.pop_front());
        end
        if (b_wr) begin
          check("b_wr_expected", exp_wr_b.size() > 0, 1);
          if (exp_wr_b.size() > 0) begin
            e = exp_wr_b.pop_front();
            check("b_wr_idx", b_idx, e.idx);
            check("b_fill_done", b_done, e.last);
          end
        end
        if (b_done) b_done_seen++;
      end
    end
  end

  initial begin : seq
    int k, target;
    rst = 1'b1;
    miss_detected = 1'b0; miss_address = '0; cwf_mode = 1'b0;
    mem_req_ready = 1'b0; memory_data_valid = 1'b0;
    b_miss = 1'b0; b_addr = '0; b_cwf = 1'b0; b_ready = 1'b0; b_mdv = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", {mem_req_valid, mem_req_addr, fsm_busy, write_data_array,
                            write_word_idx, write_tag_array, fill_done}, 0);
    check("b_reset_outputs", {b_req_valid, b_req_addr, b_busy, b_wr, b_idx, b_tag, b_done}, 0);
    tick();
    rst = 1'b0;

    // Responses while idle must be ignored.
    bogus = 1'b1;
    repeat (3) tick();
    bogus = 1'b0;

    // Wider words, smaller block, wrap at the top of the address space.
    push_fill(32'hFFF8, 1'b1, 4, 4, 1'b1);
    tick();
    b_miss = 1'b1; b_addr = 16'hFFF8; b_cwf = 1'b1;
    tick();
    b_miss = 1'b0; b_addr = 16'h0;
    k = 0;
    while (b_done_seen < 1 && k < 100) begin tick(); k++; end
    check("b_fill_timeout", b_done_seen, 1);
    check("b_left_over", exp_req_b.size() + exp_wr_b.size(), 0);

    run_fill(16'h1236, 1'b0, 0, 4);
    run_fill(16'h123A, 1'b1, 0, 4);
    run_fill(16'h1236, 1'b0, 1, 4);

    // Responses before any request is accepted are protocol errors.
    lat = 3;
    ready_mode = 3;
    start_fill(16'h2A4C, 1'b1);
    bogus = 1'b1;
    repeat (2) tick();
    bogus = 1'b0;
    ready_mode = 0;
    wait_done(600);

    // Reset after three responses; later pulses must not write.
    lat = 4;
    ready_mode = 0;
    start_fill(16'h5556, 1'b1);
    target = wr_total + 3;
    k = 0;
    while (wr_total < target && k < 200) begin tick(); k++; end
    check("midfill_progress", wr_total >= target, 1);
    tick();
    rst = 1'b1;
    memory_data_valid = 1'b0;
    exp_req.delete(); exp_wr.delete(); pend.delete();
    tick();
    rst = 1'b0;
    bogus = 1'b1;
    memory_data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_quiet", {write_data_array, write_tag_array, fill_done, fsm_busy, mem_req_valid}, 0);
      if (i == 4) bogus = 1'b0;
      tick();
    end
    @(negedge clk);
    check("post_rst_outputs", {mem_req_valid, mem_req_addr, fsm_busy, write_data_array,
                               write_word_idx, write_tag_array, fill_done}, 0);

    // Back-to-back: miss held high through fill_done with the next address.
    lat = 2;
    push_fill(32'h7A12, 1'b1, 2, 8, 1'b0);
    push_fill(32'h4000, 1'b0, 2, 8, 1'b0);
    tick();
    miss_detected = 1'b1; miss_address = 16'h7A12; cwf_mode = 1'b1;
    tick();
    miss_address = 16'h4000; cwf_mode = 1'b0;
    wait_done(600);
    @(negedge clk);
    check("b2b_gap_busy", fsm_busy, 0);
    tick();
    miss_detected = 1'b0;
    @(negedge clk);
    check("b2b_second_valid", mem_req_valid, 1);
    check("b2b_second_addr", mem_req_addr, 16'h4000);
    wait_done(600);

    for (int r = 0; r < 10; r++) begin
      run_fill(16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
               $urandom_range(1, 6));
    end
    repeat (3) tick();
    check("left_over", exp_req.size() + exp_wr.size() + pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
